// File: rtl/load_unit_ctrl.sv
`timescale 1ns/1ps
// Load unit controller: sequences one RV32I load at a time from execute to the data bus,
// with alignment check, response timeout, byte/half extraction and a valid/ready result.
package instr_type;
  typedef enum logic [2:0] {
    lk_lb      = 3'd0,
    lk_lh      = 3'd1,
    lk_lw      = 3'd2,
    lk_lbu     = 3'd3,
    lk_lhu     = 3'd4,
    lk_invalid = 3'd7
  } load_kind_t;
endpackage

module load_unit_ctrl
  import instr_type::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  load_kind_t  i_req_kind,
  input  logic [31:0] i_req_addr,
  input  logic [4:0]  i_req_rd,
  output logic        o_mem_req_valid,
  input  logic        i_mem_req_ready,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_rsp_valid,
  input  logic [31:0] i_mem_rsp_data,
  input  logic        i_mem_rsp_err,
  output logic        o_res_valid,
  input  logic        i_res_ready,
  output logic [4:0]  o_res_rd,
  output logic [31:0] o_res_data,
  output logic        o_res_exc,
  output logic [3:0]  o_res_cause,
  output logic [31:0] o_res_tval
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t        r_state, w_next_state;
  logic          r_drain, w_next_drain;
  logic [TW-1:0] r_timer;
  load_kind_t    r_kind;
  logic [31:0]   r_addr;
  logic [4:0]    r_rd;
  logic          r_req_ready, r_mem_req_valid, r_res_valid;
  logic          w_req_ready_nxt, w_mem_req_valid_nxt, w_res_valid_nxt;
  logic [31:0]   r_data, r_tval;
  logic          r_exc;
  logic [3:0]    r_cause;
  logic          w_accept, w_illegal, w_misaligned, w_timeout;

  function automatic logic kind_legal(input load_kind_t kind);
    case (kind)
      lk_lb, lk_lh, lk_lw, lk_lbu, lk_lhu: kind_legal = 1'b1;
      default:                             kind_legal = 1'b0;
    endcase
  endfunction

  function automatic logic kind_misaligned(input load_kind_t kind, input logic [1:0] off);
    case (kind)
      lk_lh, lk_lhu: kind_misaligned = off[0];
      lk_lw:         kind_misaligned = (off != 2'b00);
      default:       kind_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] extract(input load_kind_t kind, input logic [1:0] off,
                                          input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (kind)
      lk_lb:   extract = {{24{b[7]}}, b};
      lk_lbu:  extract = {24'd0, b};
      lk_lh:   extract = {{16{h[15]}}, h};
      lk_lhu:  extract = {16'd0, h};
      lk_lw:   extract = word;
      default: extract = 32'd0;
    endcase
  endfunction

  assign w_accept     = (r_state == S_IDLE) && i_req_valid && r_req_ready;
  assign w_illegal    = !kind_legal(i_req_kind);
  assign w_misaligned = kind_misaligned(i_req_kind, i_req_addr[1:0]);
  // A response in the last WAIT cycle still wins over the timeout.
  assign w_timeout    = (r_state == S_WAIT) && !i_mem_rsp_valid && (r_timer == TMO_LAST);

  // State register, drain flag, WAIT timer and registered handshake outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state         <= S_IDLE;
      r_drain         <= 1'b0;
      r_timer         <= '0;
      r_req_ready     <= 1'b0;
      r_mem_req_valid <= 1'b0;
      r_res_valid     <= 1'b0;
    end else begin
      r_state         <= w_next_state;
      r_drain         <= w_next_drain;
      r_req_ready     <= w_req_ready_nxt;
      r_mem_req_valid <= w_mem_req_valid_nxt;
      r_res_valid     <= w_res_valid_nxt;
      if (r_state == S_REQ) begin
        r_timer <= '0;
      end else if (r_state == S_WAIT) begin
        r_timer <= r_timer + TW'(1);
      end
    end
  end

  // Next-state and drain logic.
  always_comb begin
    w_next_state = r_state;
    w_next_drain = r_drain;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = (w_illegal || w_misaligned) ? S_RESP : S_REQ;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_REQ:  w_next_state = i_mem_req_ready ? S_WAIT : S_REQ;
      S_WAIT: w_next_state = (i_mem_rsp_valid || w_timeout) ? S_RESP : S_WAIT;
      S_RESP: w_next_state = i_res_ready ? S_IDLE : S_RESP;
      default: w_next_state = S_IDLE;
    endcase
    if (w_timeout) begin
      w_next_drain = 1'b1;
    end else if (r_drain && i_mem_rsp_valid && (r_state != S_WAIT)) begin
      w_next_drain = 1'b0;
    end else begin
      w_next_drain = r_drain;
    end
  end

  // Output decode from the next state, registered above.
  always_comb begin
    w_req_ready_nxt     = (w_next_state == S_IDLE) && !w_next_drain;
    w_mem_req_valid_nxt = (w_next_state == S_REQ);
    w_res_valid_nxt     = (w_next_state == S_RESP);
  end

  // Request capture and result formation.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_kind  <= lk_lb;
      r_addr  <= 32'd0;
      r_rd    <= 5'd0;
      r_data  <= 32'd0;
      r_exc   <= 1'b0;
      r_cause <= 4'd0;
      r_tval  <= 32'd0;
    end else if (w_accept) begin
      r_kind  <= i_req_kind;
      r_addr  <= i_req_addr;
      r_rd    <= i_req_rd;
      r_data  <= 32'd0;
      r_exc   <= w_illegal || w_misaligned;
      r_cause <= w_illegal ? 4'd2 : (w_misaligned ? 4'd4 : 4'd0);
      r_tval  <= (!w_illegal && w_misaligned) ? i_req_addr : 32'd0;
    end else if ((r_state == S_WAIT) && (i_mem_rsp_valid || w_timeout)) begin
      if (w_timeout || i_mem_rsp_err) begin
        r_data  <= 32'd0;
        r_exc   <= 1'b1;
        r_cause <= 4'd5;
        r_tval  <= r_addr;
      end else begin
        r_data  <= extract(r_kind, r_addr[1:0], i_mem_rsp_data);
        r_exc   <= 1'b0;
        r_cause <= 4'd0;
        r_tval  <= 32'd0;
      end
    end
  end

  assign o_req_ready     = r_req_ready;
  assign o_mem_req_valid = r_mem_req_valid;
  assign o_mem_addr      = {r_addr[31:2], 2'b00};
  assign o_res_valid     = r_res_valid;
  assign o_res_rd        = r_rd;
  assign o_res_data      = r_data;
  assign o_res_exc       = r_exc;
  assign o_res_cause     = r_cause;
  assign o_res_tval      = r_tval;

endmodule

// File: tb/tb_load_unit_ctrl.sv
`timescale 1ns/1ps
// Randomized self-checking bench for load_unit_ctrl against a behavioural load model.
module tb_load_unit_ctrl;
  import instr_type::*;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid, i_mem_req_ready, i_mem_rsp_valid, i_mem_rsp_err, i_res_ready;
  load_kind_t  i_req_kind;
  logic [31:0] i_req_addr, i_mem_rsp_data;
  logic [4:0]  i_req_rd;
  logic        o_req_ready, o_mem_req_valid, o_res_valid, o_res_exc;
  logic [31:0] o_mem_addr, o_res_data, o_res_tval;
  logic [4:0]  o_res_rd;
  logic [3:0]  o_res_cause;

  int n_checks = 0;
  int n_err    = 0;
  int hs_count = 0;
  int dead_count = 0;

  always #5 clk = ~clk;

  load_unit_ctrl #(.TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_kind(i_req_kind),
    .i_req_addr(i_req_addr), .i_req_rd(i_req_rd),
    .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready), .o_mem_addr(o_mem_addr),
    .i_mem_rsp_valid(i_mem_rsp_valid), .i_mem_rsp_data(i_mem_rsp_data), .i_mem_rsp_err(i_mem_rsp_err),
    .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_res_rd(o_res_rd),
    .o_res_data(o_res_data), .o_res_exc(o_res_exc), .o_res_cause(o_res_cause), .o_res_tval(o_res_tval)
  );

  always @(posedge clk) begin
    if (!rst && o_res_valid && i_res_ready) begin
      hs_count <= hs_count + 1;
      if (o_res_data == 32'hDEAD_BEEF) dead_count <= dead_count + 1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct packed {
    logic        mem;
    logic        exc;
    logic [3:0]  cause;
    logic [31:0] tval;
    logic [31:0] data;
  } exp_t;

  // Architectural outcome of one load, from the kind/address rules and the bus reply.
  function automatic exp_t ref_load(input load_kind_t k, input logic [31:0] a,
                                    input logic [31:0] w, input logic err, input logic tmo);
    exp_t e;
    int unsigned b, h;
    e = '0;
    if (!(k inside {lk_lb, lk_lh, lk_lw, lk_lbu, lk_lhu})) begin
      e.exc = 1'b1; e.cause = 4'd2;
      return e;
    end
    if (((k == lk_lh || k == lk_lhu) && (a % 32'd2 != 32'd0)) || (k == lk_lw && (a % 32'd4 != 32'd0))) begin
      e.exc = 1'b1; e.cause = 4'd4; e.tval = a;
      return e;
    end
    e.mem = 1'b1;
    if (err || tmo) begin
      e.exc = 1'b1; e.cause = 4'd5; e.tval = a;
      return e;
    end
    b = (w >> (32'd8 * (a % 32'd4))) % 32'd256;
    h = (w >> (32'd16 * ((a / 32'd2) % 32'd2))) % 32'd65536;
    case (k)
      lk_lb:   e.data = (b >= 32'd128) ? b - 32'd256 : b;
      lk_lbu:  e.data = b;
      lk_lh:   e.data = (h >= 32'd32768) ? h - 32'd65536 : h;
      lk_lhu:  e.data = h;
      default: e.data = w;
    endcase
    return e;
  endfunction

  task automatic run_load(input load_kind_t k, input logic [31:0] a, input logic [4:0] rd,
                          input logic [31:0] w, input logic err, input int gnt, input int rsp,
                          input logic tmo, input int stall);
    exp_t e;
    int exp_lat, lat, cyc, gcnt, rcnt, scnt, n_grant;
    logic accepted, granted, grant_now, rsp_sent, seen_res, done, bad_rdy, bad_addr, bad_stable;
    logic [4:0] s_rd;
    logic [31:0] s_data, s_tval;
    logic s_exc;
    logic [3:0] s_cause;
    e = ref_load(k, a, w, err, tmo);
    exp_lat = e.mem ? (3 + gnt + (tmo ? TMO - 1 : rsp)) : 1;
    lat = 0; gcnt = 0; rcnt = 0; scnt = 0; n_grant = 0;
    accepted = 1'b0; granted = 1'b0; rsp_sent = 1'b0; seen_res = 1'b0; done = 1'b0;
    bad_rdy = 1'b0; bad_addr = 1'b0; bad_stable = 1'b0;
    s_rd = '0; s_data = '0; s_tval = '0; s_exc = 1'b0; s_cause = '0;
    i_req_valid = 1'b1; i_req_kind = k; i_req_addr = a; i_req_rd = rd;
    for (int t = 0; t < 20 && !accepted; t++) begin
      if (o_req_ready) accepted = 1'b1;
      @(posedge clk); #1;
    end
    i_req_valid = 1'b0;
    check_eq("accept", 128'(accepted), 128'(1));
    cyc = 1;
    while (accepted && !done && cyc < 100) begin
      i_mem_req_ready = 1'b0; i_mem_rsp_valid = 1'b0; i_mem_rsp_err = 1'b0; i_res_ready = 1'b0;
      grant_now = 1'b0;
      if (o_req_ready) bad_rdy = 1'b1;
      if (o_mem_req_valid) begin
        if (o_mem_addr !== (a & 32'hFFFF_FFFC)) bad_addr = 1'b1;
        if (gcnt == gnt) begin
          i_mem_req_ready = 1'b1; grant_now = 1'b1; n_grant++;
        end
        gcnt++;
      end
      if (granted && !tmo && !rsp_sent) begin
        if (rcnt == rsp) begin
          i_mem_rsp_valid = 1'b1; i_mem_rsp_data = w; i_mem_rsp_err = err; rsp_sent = 1'b1;
        end
        rcnt++;
      end
      if (o_res_valid) begin
        if (!seen_res) begin
          seen_res = 1'b1; lat = cyc;
          s_rd = o_res_rd; s_data = o_res_data; s_tval = o_res_tval; s_exc = o_res_exc; s_cause = o_res_cause;
        end else if ({o_res_rd, o_res_data, o_res_tval, o_res_exc, o_res_cause} !==
                     {s_rd, s_data, s_tval, s_exc, s_cause}) begin
          bad_stable = 1'b1;
        end
        if (scnt == stall) begin
          i_res_ready = 1'b1; done = 1'b1;
        end
        scnt++;
      end
      @(posedge clk); #1;
      if (grant_now) granted = 1'b1;
      cyc++;
    end
    i_mem_req_ready = 1'b0; i_mem_rsp_valid = 1'b0; i_mem_rsp_err = 1'b0; i_res_ready = 1'b0;
    check_eq("res_handshake", 128'(done), 128'(1));
    check_eq("latency", 128'(lat), 128'(exp_lat));
    check_eq("mem_grants", 128'(n_grant), 128'(e.mem));
    check_eq("mem_addr", 128'(bad_addr), 128'(0));
    check_eq("busy_ready", 128'(bad_rdy), 128'(0));
    check_eq("res_stable", 128'(bad_stable), 128'(0));
    check_eq("res_rd", 128'(s_rd), 128'(rd));
    check_eq("res_exc", 128'(s_exc), 128'(e.exc));
    check_eq("res_cause", 128'(s_cause), 128'(e.cause));
    check_eq("res_tval", 128'(s_tval), 128'(e.tval));
    check_eq("res_data", 128'(s_data), 128'(e.data));
    check_eq("post_valid", 128'(o_res_valid), 128'(0));
    check_eq("post_ready", 128'(o_req_ready), 128'(!(e.mem && tmo)));
  endtask

  load_kind_t kinds [6] = '{lk_lb, lk_lh, lk_lw, lk_lbu, lk_lhu, lk_invalid};

  initial begin
    int hs0, dead0;
    logic bad;
    logic [31:0] ra;
    load_kind_t rk;
    rst = 1'b1;
    i_req_valid = 1'b0; i_req_kind = lk_lb; i_req_addr = 32'd0; i_req_rd = 5'd0;
    i_mem_req_ready = 1'b0; i_mem_rsp_valid = 1'b0; i_mem_rsp_data = 32'd0; i_mem_rsp_err = 1'b0;
    i_res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs", 128'({o_req_ready, o_mem_req_valid, o_mem_addr, o_res_valid, o_res_rd,
                                     o_res_data, o_res_exc, o_res_cause, o_res_tval}), 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("ready_after_reset", 128'(o_req_ready), 128'(1));

    run_load(lk_lbu, 32'h0000_1003, 5'd1, 32'h80FF_1234, 1'b0, 0, 0, 1'b0, 0);
    run_load(lk_lh,  32'h0000_2002, 5'd2, 32'h8001_0000, 1'b0, 0, 0, 1'b0, 0);
    run_load(lk_lhu, 32'h0000_2002, 5'd3, 32'h8001_0000, 1'b0, 0, 0, 1'b0, 0);
    run_load(lk_lw,  32'h0000_2000, 5'd4, 32'h8001_0000, 1'b0, 0, 0, 1'b0, 0);
    run_load(lk_lw,  32'h0000_3001, 5'd5, 32'h1111_1111, 1'b0, 0, 0, 1'b0, 0);
    run_load(lk_invalid, 32'h0000_3001, 5'd6, 32'h1111_1111, 1'b0, 0, 0, 1'b0, 0);
    run_load(lk_lh,  32'h0000_2003, 5'd7, 32'h1111_1111, 1'b0, 0, 0, 1'b0, 0);
    run_load(lk_lb,  32'h0000_0007, 5'd8, 32'hAABB_CCDD, 1'b0, 1, 1, 1'b0, 0);
    run_load(lk_lw,  32'h0000_6004, 5'd9, 32'h5555_AAAA, 1'b1, 5, 2, 1'b0, 0);
    run_load(lk_lh,  32'h0000_2000, 5'd10, 32'h1234_7FFF, 1'b0, 0, 0, 1'b0, 4);

    // Timeout, then a late beat that must be swallowed before new work is taken.
    run_load(lk_lb, 32'h0000_8001, 5'd11, 32'h0, 1'b0, 1, 0, 1'b1, 1);
    bad = 1'b0;
    repeat (3) begin
      if (o_req_ready || o_res_valid) bad = 1'b1;
      @(posedge clk); #1;
    end
    check_eq("drain_blocks", 128'(bad), 128'(0));
    i_mem_rsp_valid = 1'b1; i_mem_rsp_data = 32'h7777_7777;
    @(posedge clk); #1;
    i_mem_rsp_valid = 1'b0;
    check_eq("drain_clear", 128'(o_req_ready), 128'(1));
    check_eq("drain_no_result", 128'(o_res_valid), 128'(0));
    run_load(lk_lb, 32'h0000_8001, 5'd12, 32'h0000_8000, 1'b0, 0, 0, 1'b0, 0);

    // Reset in WAIT, then a stale beat, then a clean load.
    i_req_valid = 1'b1; i_req_kind = lk_lw; i_req_addr = 32'h0000_5000; i_req_rd = 5'd13;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    check_eq("rst_pre_req", 128'(o_mem_req_valid), 128'(1));
    i_mem_req_ready = 1'b1;
    @(posedge clk); #1;
    i_mem_req_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_eq("rst_mid_outputs", 128'({o_req_ready, o_mem_req_valid, o_mem_addr, o_res_valid, o_res_rd,
                                       o_res_data, o_res_exc, o_res_cause, o_res_tval}), 128'(0));
    @(posedge clk); #1;
    check_eq("rst_hold_outputs", 128'({o_req_ready, o_mem_req_valid, o_res_valid, o_mem_addr}), 128'(0));
    rst = 1'b0;
    i_mem_rsp_valid = 1'b1; i_mem_rsp_data = 32'h1234_5678;
    @(posedge clk); #1;
    i_mem_rsp_valid = 1'b0;
    check_eq("rst_ready", 128'(o_req_ready), 128'(1));
    check_eq("rst_stale_ignored", 128'(o_res_valid), 128'(0));
    hs0 = hs_count; dead0 = dead_count;
    run_load(lk_lw, 32'h0000_4000, 5'd14, 32'hDEAD_BEEF, 1'b0, 0, 0, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("dead_once", 128'(dead_count - dead0), 128'(1));
    check_eq("hs_once", 128'(hs_count - hs0), 128'(1));

    for (int i = 0; i < 60; i++) begin
      rk = kinds[$urandom_range(0, 5)];
      ra = $urandom;
      if ($urandom_range(0, 1) == 1) ra = ra & 32'hFFFF_FFFC;
      run_load(rk, ra, 5'($urandom_range(0, 31)), $urandom, ($urandom_range(0, 7) == 0),
               $urandom_range(0, 3), $urandom_range(0, 2), 1'b0, $urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) begin
        i_mem_rsp_valid = 1'b1; i_mem_rsp_data = $urandom;
        @(posedge clk); #1;
        i_mem_rsp_valid = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
